// File: rtl/cp0_pkg.sv
// Coprocessor-0 shared definitions: register indices, mux encodings,
// default vector/reset constants and STATUS stack helpers.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [31:0] DEF_EXC_BASE  = 32'h0000_0008;
    localparam logic [31:0] DEF_RESET_STA = 32'h0000_0000;

    typedef enum logic [1:0] {
        SELPC_NPC     = 2'b00,
        SELPC_EPC     = 2'b01,
        SELPC_EXC     = 2'b10,
        SELPC_NPC_ALT = 2'b11
    } selpc_e;

    typedef enum logic [1:0] {
        MFC0_ALU = 2'b00,
        MFC0_STA = 2'b01,
        MFC0_CAU = 2'b10,
        MFC0_EPC = 2'b11
    } mfc0_e;

    // STATUS keeps a 4-bit mask stack: exception entry pushes zeros in,
    // eret pops the previous mask back.
    function automatic logic [31:0] sta_push(input logic [31:0] sta);
        return {sta[27:0], 4'h0};
    endfunction

    function automatic logic [31:0] sta_pop(input logic [31:0] sta);
        return {4'h0, sta[31:4]};
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Decoder <-> CP0 signal bundle. master = decoder side, slave = CP0 side.
// With CP0_TIMER_EN defined the bundle also carries rd and count_o.
interface cp0_regfile_if;
    logic        mtc0;
    logic        wsta;
    logic        wcau;
    logic        wepc;
    logic        exc;
    logic        inta;
    logic [1:0]  selpc;
    logic [1:0]  mfc0;
    logic [31:0] cause_in;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] alu_mem;
    logic [31:0] sta;
    logic [31:0] cau;
    logic [31:0] epc;
    logic [31:0] next_pc;
    logic [31:0] wb_data;
    logic        intr;
`ifdef CP0_TIMER_EN
    logic [4:0]  rd;
    logic [31:0] count_o;

    modport master (
        output mtc0, wsta, wcau, wepc, exc, inta, selpc, mfc0,
               cause_in, wdata, pc, npc, alu_mem, rd,
        input  sta, cau, epc, next_pc, wb_data, intr, count_o
    );
    modport slave (
        input  mtc0, wsta, wcau, wepc, exc, inta, selpc, mfc0,
               cause_in, wdata, pc, npc, alu_mem, rd,
        output sta, cau, epc, next_pc, wb_data, intr, count_o
    );
`else
    modport master (
        output mtc0, wsta, wcau, wepc, exc, inta, selpc, mfc0,
               cause_in, wdata, pc, npc, alu_mem,
        input  sta, cau, epc, next_pc, wb_data, intr
    );
    modport slave (
        input  mtc0, wsta, wcau, wepc, exc, inta, selpc, mfc0,
               cause_in, wdata, pc, npc, alu_mem,
        output sta, cau, epc, next_pc, wb_data, intr
    );
`endif
endinterface

// File: rtl/cp0_regfile_irq_sync.sv
// irq_sync: 2-flop synchroniser, rising-edge detect and a set/clear pending
// latch for one asynchronous level interrupt line. Set beats clear.
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    input  logic clr_i,
    output logic pend_o
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       pend_q;
    logic       pend_d;
    logic       rise;

    // Two-stage synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise = sync_q[1] & ~prev_q;

    // A new edge keeps the request alive even if it is acknowledged now.
    always_comb begin
        pend_d = pend_q;
        if (rise) begin
            pend_d = 1'b1;
        end else if (clr_i) begin
            pend_d = 1'b0;
        end
    end

    // Pending request register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: STATUS/CAUSE/EPC state, next-PC and write-back muxes and the
// external interrupt request. Optional timer (COUNT/COMPARE) is built when
// the macro CP0_TIMER_EN is defined.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_BASE  = DEF_EXC_BASE,
    parameter logic [31:0] RESET_STA = DEF_RESET_STA
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           irq,
    cp0_regfile_if.slave   bus
);

    logic [31:0] sta_q, sta_d;
    logic [31:0] cau_q, cau_d;
    logic [31:0] epc_q, epc_d;
    logic        irq_pend;
    logic        timer_pend;
    selpc_e      selpc;
    mfc0_e       mfc0;

    assign selpc = selpc_e'(bus.selpc);
    assign mfc0  = mfc0_e'(bus.mfc0);

    // Next state of the architectural registers; exc outranks mtc0 everywhere.
    always_comb begin
        sta_d = sta_q;
        cau_d = cau_q;
        epc_d = epc_q;
        if (bus.wsta) begin
            if (bus.exc) begin
                sta_d = sta_push(sta_q);
            end else if (bus.mtc0) begin
                sta_d = bus.wdata;
            end else if (selpc == SELPC_EPC) begin
                sta_d = sta_pop(sta_q);
            end
        end
        if (bus.wcau) begin
            cau_d = bus.exc ? bus.cause_in : bus.wdata;
        end
        if (bus.wepc) begin
            if (bus.exc) begin
                // An interrupted instruction retires, so resume after it.
                epc_d = bus.inta ? bus.npc : bus.pc;
            end else begin
                epc_d = bus.wdata;
            end
        end
    end

    // Architectural register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sta_q <= RESET_STA;
            cau_q <= 32'h0;
            epc_q <= 32'h0;
        end else begin
            sta_q <= sta_d;
            cau_q <= cau_d;
            epc_q <= epc_d;
        end
    end

    // Next-PC select uses the pre-edge EPC so eret returns immediately.
    always_comb begin
        bus.next_pc = bus.npc;
        unique case (selpc)
            SELPC_NPC:     bus.next_pc = bus.npc;
            SELPC_EPC:     bus.next_pc = epc_q;
            SELPC_EXC:     bus.next_pc = EXC_BASE;
            SELPC_NPC_ALT: bus.next_pc = bus.npc;
        endcase
    end

    // Write-back mux returns current register contents, no write bypass.
    always_comb begin
        bus.wb_data = bus.alu_mem;
        unique case (mfc0)
            MFC0_ALU: bus.wb_data = bus.alu_mem;
            MFC0_STA: bus.wb_data = sta_q;
            MFC0_CAU: bus.wb_data = cau_q;
            MFC0_EPC: bus.wb_data = epc_q;
        endcase
    end

    irq_sync u_irq_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(irq),
        .clr_i  (bus.inta),
        .pend_o (irq_pend)
    );

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tpend_q, tpend_d;
    logic        wr_count;
    logic        wr_compare;

    assign wr_count   = bus.mtc0 & ~bus.exc & (bus.rd == CP0_COUNT);
    assign wr_compare = bus.mtc0 & ~bus.exc & (bus.rd == CP0_COMPARE);

    // Free-running counter, compare match and timer request next state.
    always_comb begin
        count_d   = wr_count ? bus.wdata : count_q + 32'd1;
        compare_d = wr_compare ? bus.wdata : compare_q;
        tpend_d   = tpend_q;
        if (wr_compare) begin
            tpend_d = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'h0)) begin
            tpend_d = 1'b1;
        end else if (bus.inta) begin
            tpend_d = 1'b0;
        end
    end

    // Timer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            tpend_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tpend_q   <= tpend_d;
        end
    end

    assign timer_pend  = tpend_q;
    assign bus.count_o = count_q;
`else
    assign timer_pend = 1'b0;
`endif

    assign bus.sta  = sta_q;
    assign bus.cau  = cau_q;
    assign bus.epc  = epc_q;
    assign bus.intr = irq_pend | timer_pend;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios followed by a
// randomized run against a behavioural model. Timer scenario is compiled
// only with CP0_TIMER_EN.
module tb_cp0_regfile;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    cp0_regfile_if bus ();

    cp0_regfile dut (
        .clk(clk),
        .rst(rst),
        .irq(irq),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.mtc0 = 0; bus.wsta = 0; bus.wcau = 0; bus.wepc = 0;
        bus.exc = 0; bus.inta = 0; bus.selpc = 2'b00; bus.mfc0 = 2'b00;
        bus.cause_in = 0; bus.wdata = 0; bus.pc = 0; bus.npc = 0;
        bus.alu_mem = 0;
`ifdef CP0_TIMER_EN
        bus.rd = 5'd0;
`endif
    endtask

    task automatic do_reset;
        idle_inputs();
        irq = 0;
        rst = 1;
        step(); step();
        rst = 0;
    endtask

    task automatic test_reset;
        total_cnt++; if (bus.sta !== 32'h0) $display("FAIL rst_sta got %h want %h", bus.sta, 32'h0); else pass_cnt++;
        total_cnt++; if (bus.intr !== 1'b0) $display("FAIL rst_intr got %b want 0", bus.intr); else pass_cnt++;
        bus.mtc0 = 1; bus.wsta = 1; bus.wcau = 1; bus.wepc = 1; bus.wdata = 32'hF;
        irq = 1;
        step();
        idle_inputs();
        step(); step();
        total_cnt++; if (bus.sta !== 32'hF) $display("FAIL pre_sta got %h want %h", bus.sta, 32'hF); else pass_cnt++;
        total_cnt++; if (bus.intr !== 1'b1) $display("FAIL pre_intr got %b want 1", bus.intr); else pass_cnt++;
        bus.npc = 32'h1234;
        #3 rst = 1;
        #1;
        total_cnt++; if (bus.sta !== 32'h0) $display("FAIL async_sta got %h want 0", bus.sta); else pass_cnt++;
        total_cnt++; if (bus.cau !== 32'h0) $display("FAIL async_cau got %h want 0", bus.cau); else pass_cnt++;
        total_cnt++; if (bus.epc !== 32'h0) $display("FAIL async_epc got %h want 0", bus.epc); else pass_cnt++;
        total_cnt++; if (bus.intr !== 1'b0) $display("FAIL async_intr got %b want 0", bus.intr); else pass_cnt++;
        total_cnt++; if (bus.next_pc !== 32'h1234) $display("FAIL rst_next_pc got %h want %h", bus.next_pc, 32'h1234); else pass_cnt++;
        irq = 0;
        step();
        rst = 0;
        step(); step(); step();
        total_cnt++; if (bus.intr !== 1'b0) $display("FAIL post_rst_intr got %b want 0", bus.intr); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_push_pop;
        bus.mtc0 = 1; bus.wsta = 1; bus.wdata = 32'hF;
        step();
        idle_inputs();
        bus.exc = 1; bus.inta = 0; bus.wsta = 1; bus.wcau = 1; bus.wepc = 1;
        bus.pc = 32'h40; bus.npc = 32'h44; bus.cause_in = 32'h4; bus.selpc = 2'b10;
        #1;
        total_cnt++; if (bus.next_pc !== 32'h8) $display("FAIL exc_next_pc got %h want %h", bus.next_pc, 32'h8); else pass_cnt++;
        step();
        idle_inputs();
        total_cnt++; if (bus.sta !== 32'hF0) $display("FAIL push_sta got %h want %h", bus.sta, 32'hF0); else pass_cnt++;
        total_cnt++; if (bus.epc !== 32'h40) $display("FAIL exc_epc got %h want %h", bus.epc, 32'h40); else pass_cnt++;
        total_cnt++; if (bus.cau !== 32'h4) $display("FAIL exc_cau got %h want %h", bus.cau, 32'h4); else pass_cnt++;
        bus.selpc = 2'b01; bus.wsta = 1; bus.npc = 32'h99;
        #1;
        total_cnt++; if (bus.next_pc !== 32'h40) $display("FAIL eret_next_pc got %h want %h", bus.next_pc, 32'h40); else pass_cnt++;
        step();
        idle_inputs();
        total_cnt++; if (bus.sta !== 32'hF) $display("FAIL pop_sta got %h want %h", bus.sta, 32'hF); else pass_cnt++;
    endtask

    task automatic test_mtc0_readback;
        bus.mtc0 = 1; bus.wcau = 1; bus.wdata = 32'hDEAD_BEEF; bus.mfc0 = 2'b10;
        #1;
        total_cnt++; if (bus.wb_data !== 32'h4) $display("FAIL no_bypass got %h want %h", bus.wb_data, 32'h4); else pass_cnt++;
        step();
        idle_inputs();
        total_cnt++; if (bus.cau !== 32'hDEAD_BEEF) $display("FAIL mtc0_cau got %h want %h", bus.cau, 32'hDEAD_BEEF); else pass_cnt++;
        bus.mfc0 = 2'b10; bus.alu_mem = 32'h5555_AAAA;
        #1;
        total_cnt++; if (bus.wb_data !== 32'hDEAD_BEEF) $display("FAIL mfc0_cau got %h want %h", bus.wb_data, 32'hDEAD_BEEF); else pass_cnt++;
        bus.mfc0 = 2'b00;
        #1;
        total_cnt++; if (bus.wb_data !== 32'h5555_AAAA) $display("FAIL mfc0_alu got %h want %h", bus.wb_data, 32'h5555_AAAA); else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_collision;
        bus.mtc0 = 1; bus.wsta = 1; bus.wdata = 32'h3;
        step();
        bus.exc = 1; bus.mtc0 = 1; bus.wsta = 1; bus.wdata = 32'h1234;
        step();
        idle_inputs();
        total_cnt++; if (bus.sta !== 32'h30) $display("FAIL collision_sta got %h want %h", bus.sta, 32'h30); else pass_cnt++;
    endtask

    task automatic test_interrupt;
        irq = 1;
        step();
        total_cnt++; if (bus.intr !== 1'b0) $display("FAIL irq_e1 got %b want 0", bus.intr); else pass_cnt++;
        step();
        total_cnt++; if (bus.intr !== 1'b0) $display("FAIL irq_e2 got %b want 0", bus.intr); else pass_cnt++;
        step();
        total_cnt++; if (bus.intr !== 1'b1) $display("FAIL irq_e3 got %b want 1", bus.intr); else pass_cnt++;
        bus.exc = 1; bus.inta = 1; bus.wepc = 1; bus.wsta = 1;
        bus.pc = 32'h100; bus.npc = 32'h104;
        step();
        idle_inputs();
        total_cnt++; if (bus.intr !== 1'b0) $display("FAIL inta_clear got %b want 0", bus.intr); else pass_cnt++;
        total_cnt++; if (bus.epc !== 32'h104) $display("FAIL inta_epc got %h want %h", bus.epc, 32'h104); else pass_cnt++;
        repeat (4) step();
        total_cnt++; if (bus.intr !== 1'b0) $display("FAIL level_once got %b want 0", bus.intr); else pass_cnt++;
        irq = 0;
        step(); step();
        irq = 1;
        step(); step();
        total_cnt++; if (bus.intr !== 1'b0) $display("FAIL rearm_early got %b want 0", bus.intr); else pass_cnt++;
        step();
        total_cnt++; if (bus.intr !== 1'b1) $display("FAIL rearm got %b want 1", bus.intr); else pass_cnt++;
        irq = 0;
        bus.inta = 1;
        step();
        idle_inputs();
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer;
        bit hit;
        do_reset();
        bus.mtc0 = 1; bus.rd = 5'd11; bus.wdata = 32'd5;
        step();
        idle_inputs();
        total_cnt++; if (bus.count_o !== 32'd1) $display("FAIL count_start got %0d want 1", bus.count_o); else pass_cnt++;
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.count_o == 32'd5) begin
                hit = 1;
                break;
            end
            step();
        end
        total_cnt++; if (!hit) $display("FAIL count_reach got %0d want 5", bus.count_o); else pass_cnt++;
        total_cnt++; if (bus.intr !== 1'b0) $display("FAIL timer_early got %b want 0", bus.intr); else pass_cnt++;
        step();
        total_cnt++; if (bus.intr !== 1'b1) $display("FAIL timer_fire got %b want 1", bus.intr); else pass_cnt++;
        bus.exc = 1; bus.inta = 1;
        step();
        idle_inputs();
        total_cnt++; if (bus.intr !== 1'b0) $display("FAIL timer_inta got %b want 0", bus.intr); else pass_cnt++;
        bus.mtc0 = 1; bus.rd = 5'd11; bus.wdata = 32'd0;
        step();
        bus.mtc0 = 1; bus.rd = 5'd9; bus.wdata = 32'hFFFF_FFFE;
        step();
        idle_inputs();
        total_cnt++; if (bus.count_o !== 32'hFFFF_FFFE) $display("FAIL count_load got %h want %h", bus.count_o, 32'hFFFF_FFFE); else pass_cnt++;
        step();
        total_cnt++; if (bus.count_o !== 32'hFFFF_FFFF) $display("FAIL count_max got %h want %h", bus.count_o, 32'hFFFF_FFFF); else pass_cnt++;
        step();
        total_cnt++; if (bus.count_o !== 32'h0) $display("FAIL count_wrap got %h want 0", bus.count_o); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            step();
            total_cnt++; if (bus.intr !== 1'b0) $display("FAIL compare_zero got %b want 0 (cycle %0d)", bus.intr, i); else pass_cnt++;
        end
    endtask
`endif

    task automatic test_random;
        logic [31:0] m_sta, m_cau, m_epc, exp_npc, exp_wb;
        logic [31:0] n_sta, n_cau, n_epc;
        bit m_pend, h1, h2, h3, rise;
        do_reset();
        m_sta = 32'h0; m_cau = 32'h0; m_epc = 32'h0;
        m_pend = 0; h1 = 0; h2 = 0; h3 = 0;
        for (int i = 0; i < 400; i++) begin
            bus.mtc0 = 1'($urandom_range(0, 1));
            bus.wsta = 1'($urandom_range(0, 1));
            bus.wcau = 1'($urandom_range(0, 1));
            bus.wepc = 1'($urandom_range(0, 1));
            bus.exc = ($urandom_range(0, 3) == 0);
            bus.inta = ($urandom_range(0, 3) == 0);
            bus.selpc = 2'($urandom_range(0, 3));
            bus.mfc0 = 2'($urandom_range(0, 3));
            bus.cause_in = $urandom; bus.wdata = $urandom;
            bus.pc = $urandom; bus.npc = $urandom; bus.alu_mem = $urandom;
            if ($urandom_range(0, 5) == 0) irq = ~irq;
            #1;
            if (bus.selpc == 2'b01) exp_npc = m_epc;
            else if (bus.selpc == 2'b10) exp_npc = 32'h8;
            else exp_npc = bus.npc;
            case (bus.mfc0)
                2'b00: exp_wb = bus.alu_mem;
                2'b01: exp_wb = m_sta;
                2'b10: exp_wb = m_cau;
                default: exp_wb = m_epc;
            endcase
            total_cnt++; if (bus.next_pc !== exp_npc) $display("FAIL rnd_next_pc[%0d] got %h want %h", i, bus.next_pc, exp_npc); else pass_cnt++;
            total_cnt++; if (bus.wb_data !== exp_wb) $display("FAIL rnd_wb_data[%0d] got %h want %h", i, bus.wb_data, exp_wb); else pass_cnt++;
            total_cnt++; if (bus.sta !== m_sta) $display("FAIL rnd_sta[%0d] got %h want %h", i, bus.sta, m_sta); else pass_cnt++;
            total_cnt++; if (bus.cau !== m_cau) $display("FAIL rnd_cau[%0d] got %h want %h", i, bus.cau, m_cau); else pass_cnt++;
            total_cnt++; if (bus.epc !== m_epc) $display("FAIL rnd_epc[%0d] got %h want %h", i, bus.epc, m_epc); else pass_cnt++;
            total_cnt++; if (bus.intr !== m_pend) $display("FAIL rnd_intr[%0d] got %b want %b", i, bus.intr, m_pend); else pass_cnt++;
            n_sta = m_sta; n_cau = m_cau; n_epc = m_epc;
            if (bus.wsta) begin
                if (bus.exc) n_sta = m_sta << 4;
                else if (bus.mtc0) n_sta = bus.wdata;
                else if (bus.selpc == 2'b01) n_sta = m_sta >> 4;
            end
            if (bus.wcau) n_cau = bus.exc ? bus.cause_in : bus.wdata;
            if (bus.wepc) n_epc = !bus.exc ? bus.wdata : (bus.inta ? bus.npc : bus.pc);
            rise = h2 && !h3;
            m_pend = rise || (m_pend && !bus.inta);
            h3 = h2; h2 = h1; h1 = irq;
            m_sta = n_sta; m_cau = n_cau; m_epc = n_epc;
            step();
        end
        idle_inputs();
        irq = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        test_reset();
        test_push_pop();
        test_mtc0_readback();
        test_collision();
        test_interrupt();
`ifdef CP0_TIMER_EN
        test_timer();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
